// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions: hazard FSM state encodings, zero-register constant,
// the ID/EX control bundle driven by the hazard block, and the load-use test.
package mips_pipe_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LDSTALL = 2'd1;
    localparam logic [1:0] ST_MDBUSY  = 2'd2;
    localparam logic [1:0] ST_FLUSH   = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_bubble;
        logic ifid_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_PASS   = '{1'b1, 1'b1, 1'b0, 1'b0};
    localparam hz_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1};

    // A load targeting $0 never creates a dependency since $0 is hardwired.
    function automatic logic load_use_hit(input logic       memread,
                                          input logic [4:0] dest,
                                          input logic [4:0] rs,
                                          input logic [4:0] rt,
                                          input logic       uses_rt);
        return memread && (dest != REG_ZERO) &&
               ((dest == rs) || (uses_rt && (dest == rt)));
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// 4-bit mult/div occupancy counter: load, non-underflowing decrement, clear, zero flag.
module md_busy_cnt
    import mips_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero
);

    logic [3:0] cnt_r;

    // Counter register; clear wins over load, load over decrement, and 0 is sticky.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r <= 4'd0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == 4'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// MIPS pipeline hazard controller: load-use stall, mult/div busy stall, taken-branch flush.
// Optional build macro HAZARD_PERF_CNT_EN adds the 32-bit stall_cycles counter output.
module hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int unsigned MD_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_dest,
    input  logic        ex_memread,
    input  logic        id_muldiv,
    input  logic        ex_branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic        md_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic       load_use_s;
    logic       cnt_load_s;
    logic       cnt_dec_s;
    logic       cnt_clr_s;
    logic       cnt_zero_s;
    hz_ctrl_t   ctrl_s;

    assign load_use_s = load_use_hit(ex_memread, ex_dest, id_rs, id_rt, id_uses_rt);

    // Next-state and counter control; a taken branch preempts every state.
    always_comb begin
        state_nxt_s = state_r;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        cnt_clr_s   = 1'b0;
        if (ex_branch_taken) begin
            state_nxt_s = ST_FLUSH;
            cnt_clr_s   = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (load_use_s) begin
                        state_nxt_s = ST_LDSTALL;
                    end else if (id_muldiv) begin
                        state_nxt_s = ST_MDBUSY;
                        cnt_load_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_LDSTALL: state_nxt_s = ST_RUN;
                ST_MDBUSY: begin
                    if (cnt_zero_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_MDBUSY;
                        cnt_dec_s   = 1'b1;
                    end
                end
                ST_FLUSH:   state_nxt_s = ST_RUN;
                default:    state_nxt_s = ST_RUN;
            endcase
        end
    end

    // Pipeline control decode; reset forces pass values even over a branch.
    always_comb begin
        ctrl_s = CTRL_PASS;
        if (rst) begin
            ctrl_s = CTRL_PASS;
        end else if (ex_branch_taken) begin
            ctrl_s = CTRL_BRANCH;
        end else if (((state_r == ST_RUN) && load_use_s) || (state_r == ST_MDBUSY)) begin
            ctrl_s = CTRL_STALL;
        end else begin
            ctrl_s = CTRL_PASS;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    md_busy_cnt u_md_busy_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr_s),
        .load     (cnt_load_s),
        .dec      (cnt_dec_s),
        .load_val (MD_LOAD),
        .zero     (cnt_zero_s)
    );

    assign pc_write    = ctrl_s.pc_write;
    assign ifid_write  = ctrl_s.ifid_write;
    assign idex_bubble = ctrl_s.idex_bubble;
    assign ifid_flush  = ctrl_s.ifid_flush;
    assign md_busy     = !rst && (state_r == ST_MDBUSY);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_r;

    // Stall cycle counter, naturally wraps to 0 after 2^32-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 32'd0;
        end else if (!ctrl_s.pc_write) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cycles = stall_cnt_r;
`endif

endmodule
